// File: rtl/kv_line_fill_responder.sv
`default_nettype none
// ============================================================================
// Module      : kv_line_fill_responder
// Description : Memory-side responder for cache line fills and write-backs.
//               A fill request reads LINE_SIZE words from a synchronous
//               single-port word RAM and returns the whole line with a
//               valid/ready handshake. A write-back writes a full line into
//               the same RAM word by word. Write-back wins over a fill
//               presented in the same cycle.
// Ports       : i_clk, i_rst (sync, active-high)
//               i_fetch_addr/i_fetch_valid/o_fetch_ready : fill request
//               o_fetch_data/o_fetch_valid/i_fetch_ready : returned line
//               i_wb_addr/i_wb_data/i_wb_valid/o_wb_ready: write-back line
//               o_mem_en/o_mem_we/o_mem_addr/o_mem_wdata/i_mem_rdata : RAM
// Options     : KV_FILL_CRITICAL_WORD_FIRST_EN - fill beats start at the
//               requested offset and wrap; words still land at their
//               natural index in o_fetch_data.
// Revision    : 1.0 - initial release
// ============================================================================
module kv_line_fill_responder #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int LINE_SIZE      = 4,
    parameter int MEM_ADDR_WIDTH = 10
) (
    input  logic                                 i_clk,
    input  logic                                 i_rst,
    input  logic [ADDR_WIDTH-1:0]                i_fetch_addr,
    input  logic                                 i_fetch_valid,
    output logic                                 o_fetch_ready,
    output logic [LINE_SIZE-1:0][DATA_WIDTH-1:0] o_fetch_data,
    output logic                                 o_fetch_valid,
    input  logic                                 i_fetch_ready,
    input  logic [ADDR_WIDTH-1:0]                i_wb_addr,
    input  logic [DATA_WIDTH*LINE_SIZE-1:0]      i_wb_data,
    input  logic                                 i_wb_valid,
    output logic                                 o_wb_ready,
    output logic                                 o_mem_en,
    output logic                                 o_mem_we,
    output logic [MEM_ADDR_WIDTH-1:0]            o_mem_addr,
    output logic [DATA_WIDTH-1:0]                o_mem_wdata,
    input  logic [DATA_WIDTH-1:0]                i_mem_rdata
);

    localparam int c_off_w  = $clog2(LINE_SIZE);
    localparam int c_cnt_w  = c_off_w + 1;
    localparam int c_base_w = MEM_ADDR_WIDTH - c_off_w;
    localparam logic [c_cnt_w-1:0] c_beats = c_cnt_w'(LINE_SIZE);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(LINE_SIZE - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_RESP  = 2'd2,
        S_WRITE = 2'd3
    } state_t;

    state_t                               r_state;
    state_t                               w_state_nxt;
    logic [c_cnt_w-1:0]                   r_cnt;
    logic [c_cnt_w-1:0]                   w_cnt_nxt;
    logic [c_base_w-1:0]                  r_base;
    logic [LINE_SIZE-1:0][DATA_WIDTH-1:0] r_wb_line;
    logic                                 w_accept_fetch;
    logic                                 w_accept_wb;
    logic [c_off_w-1:0]                   w_rd_off;
    logic [c_off_w-1:0]                   w_rd_beat;
    logic [c_off_w-1:0]                   w_cap_idx;
    logic [c_off_w-1:0]                   w_wr_beat;

    // Address bits above the RAM range (and, without critical-word-first,
    // the offset bits) are intentionally ignored.
    logic w_unused_addr;
    assign w_unused_addr = ^{i_fetch_addr, i_wb_addr};

`ifdef KV_FILL_CRITICAL_WORD_FIRST_EN
    logic [c_off_w-1:0] r_off;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_off <= '0;
        end else if (w_accept_fetch) begin
            r_off <= i_fetch_addr[c_off_w-1:0];
        end
    end

    assign w_rd_off = r_off;
`else
    assign w_rd_off = '0;
`endif

    // Beat k of a fill targets word (k + offset) mod LINE_SIZE; its data
    // returns one cycle later, when the counter has already moved to k+1.
    assign w_rd_beat = r_cnt[c_off_w-1:0] + w_rd_off;
    assign w_cap_idx = r_cnt[c_off_w-1:0] - c_off_w'(1) + w_rd_off;
    assign w_wr_beat = r_cnt[c_off_w-1:0];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_accept_fetch = 1'b0;
        w_accept_wb    = 1'b0;
        o_fetch_ready  = 1'b0;
        o_wb_ready     = 1'b0;
        o_fetch_valid  = 1'b0;
        o_mem_en       = 1'b0;
        o_mem_we       = 1'b0;
        o_mem_addr     = '0;
        o_mem_wdata    = '0;
        case (r_state)
            S_IDLE: begin
                o_wb_ready    = 1'b1;
                o_fetch_ready = ~i_wb_valid;
                w_cnt_nxt     = '0;
                if (i_wb_valid) begin
                    w_accept_wb = 1'b1;
                    w_state_nxt = S_WRITE;
                end else if (i_fetch_valid) begin
                    w_accept_fetch = 1'b1;
                    w_state_nxt    = S_READ;
                end
            end
            S_READ: begin
                // LINE_SIZE issue cycles plus one trailing cycle to catch
                // the last read word.
                if (r_cnt != c_beats) begin
                    o_mem_en   = 1'b1;
                    o_mem_addr = {r_base, w_rd_beat};
                end
                if (r_cnt == c_beats) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_RESP;
                end else begin
                    w_cnt_nxt = r_cnt + c_cnt_w'(1);
                end
            end
            S_RESP: begin
                o_fetch_valid = 1'b1;
                if (i_fetch_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_WRITE: begin
                o_mem_en    = 1'b1;
                o_mem_we    = 1'b1;
                o_mem_addr  = {r_base, w_wr_beat};
                o_mem_wdata = r_wb_line[w_wr_beat];
                if (r_cnt == c_last) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + c_cnt_w'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_base    <= '0;
            r_wb_line <= '0;
        end else if (w_accept_wb) begin
            r_base    <= i_wb_addr[MEM_ADDR_WIDTH-1:c_off_w];
            r_wb_line <= i_wb_data;
        end else if (w_accept_fetch) begin
            r_base <= i_fetch_addr[MEM_ADDR_WIDTH-1:c_off_w];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_fetch_data <= '0;
        end else if (r_state == S_READ && r_cnt != '0) begin
            o_fetch_data[w_cap_idx] <= i_mem_rdata;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_kv_line_fill_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_kv_line_fill_responder
// Description : Scoreboard bench for kv_line_fill_responder with a
//               behavioural synchronous RAM. Stimulus pushes the expected
//               line on acceptance; a monitor pops and compares at each
//               response handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_kv_line_fill_responder;

    logic                i_clk = 1'b0;
    logic                i_rst;
    logic [31:0]         i_fetch_addr;
    logic                i_fetch_valid;
    logic                o_fetch_ready;
    logic [3:0][31:0]    o_fetch_data;
    logic                o_fetch_valid;
    logic                i_fetch_ready;
    logic [31:0]         i_wb_addr;
    logic [127:0]        i_wb_data;
    logic                i_wb_valid;
    logic                o_wb_ready;
    logic                o_mem_en;
    logic                o_mem_we;
    logic [9:0]          o_mem_addr;
    logic [31:0]         o_mem_wdata;
    logic [31:0]         i_mem_rdata;

    logic [31:0]  mem [1024];
    logic [127:0] exp_q [$];
    int           n_tests = 0;
    int           n_fail  = 0;

    // Hand-computed beat address orders for the directed fills.
`ifdef KV_FILL_CRITICAL_WORD_FIRST_EN
    localparam logic [3:0][9:0] c_ord_42 = {10'h041, 10'h040, 10'h043, 10'h042};
    localparam logic [3:0][9:0] c_ord_43 = {10'h042, 10'h041, 10'h040, 10'h043};
`else
    localparam logic [3:0][9:0] c_ord_42 = {10'h043, 10'h042, 10'h041, 10'h040};
    localparam logic [3:0][9:0] c_ord_43 = {10'h043, 10'h042, 10'h041, 10'h040};
`endif
    localparam logic [3:0][9:0]  c_ord_80  = {10'h083, 10'h082, 10'h081, 10'h080};
    localparam logic [3:0][31:0] c_line_a  = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    localparam logic [3:0][31:0] c_line_wb = {32'h14, 32'h13, 32'h12, 32'h11};

    kv_line_fill_responder #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .LINE_SIZE(4), .MEM_ADDR_WIDTH(10)
    ) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_fetch_addr (i_fetch_addr),
        .i_fetch_valid(i_fetch_valid),
        .o_fetch_ready(o_fetch_ready),
        .o_fetch_data (o_fetch_data),
        .o_fetch_valid(o_fetch_valid),
        .i_fetch_ready(i_fetch_ready),
        .i_wb_addr    (i_wb_addr),
        .i_wb_data    (i_wb_data),
        .i_wb_valid   (i_wb_valid),
        .o_wb_ready   (o_wb_ready),
        .o_mem_en     (o_mem_en),
        .o_mem_we     (o_mem_we),
        .o_mem_addr   (o_mem_addr),
        .o_mem_wdata  (o_mem_wdata),
        .i_mem_rdata  (i_mem_rdata)
    );

    always #5 i_clk = ~i_clk;

    // Synchronous single-port RAM: read data appears the cycle after the read.
    always @(posedge i_clk) begin
        if (o_mem_en) begin
            if (o_mem_we) mem[o_mem_addr] <= o_mem_wdata;
            else          i_mem_rdata     <= mem[o_mem_addr];
        end
    end

    function automatic void check(string name, logic [127:0] act, logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Response monitor: every handshake must match the oldest expected line.
    always @(negedge i_clk) begin
        if (o_fetch_valid && i_fetch_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_response", 128'(o_fetch_valid), 128'd0);
            end else begin
                check("resp_line", o_fetch_data, exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_fetch(input logic [31:0] addr, input logic [3:0][9:0] ord,
                            input logic [3:0][31:0] line, input int hold);
        i_fetch_addr  = addr;
        i_fetch_valid = 1'b1;
        @(negedge i_clk);
        check("fetch_ready_idle", 128'(o_fetch_ready), 128'd1);
        tick();
        exp_q.push_back(line);
        i_fetch_valid = 1'b0;
        i_fetch_addr  = 32'h0000_0300;
        for (int k = 0; k < 4; k++) begin
            @(negedge i_clk);
            check("rd_en_we", {o_mem_en, o_mem_we}, 128'b10);
            check("rd_addr", 128'(o_mem_addr), 128'(ord[k]));
            tick();
        end
        @(negedge i_clk);
        check("rd_idle_gap", {o_mem_en, o_fetch_valid}, 128'b00);
        tick();
        for (int h = 0; h < hold; h++) begin
            @(negedge i_clk);
            check("hold_valid_rdy", {o_fetch_valid, o_fetch_ready}, 128'b10);
            check("hold_data", o_fetch_data, line);
            tick();
        end
        i_fetch_ready = 1'b1;
        @(negedge i_clk);
        check("fetch_valid_latency", 128'(o_fetch_valid), 128'd1);
        tick();
        i_fetch_ready = 1'b0;
        @(negedge i_clk);
        check("post_hs_idle", {o_fetch_valid, o_fetch_ready}, 128'b01);
        tick();
    endtask

    initial begin
        for (int i = 0; i < 4; i++) mem[64+i] <= 32'hA0 + i;
        i_rst = 1'b1; i_fetch_addr = '0; i_fetch_valid = 1'b0; i_fetch_ready = 1'b0;
        i_wb_addr = '0; i_wb_data = '0; i_wb_valid = 1'b0;
        repeat (3) tick();
        @(negedge i_clk);
        check("rst_mem", {o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata}, 128'd0);
        check("rst_fetch", {o_fetch_valid, o_fetch_data}, 128'd0);
        tick();
        i_rst = 1'b0;
        @(negedge i_clk);
        check("idle_ready", {o_fetch_ready, o_wb_ready}, 128'b11);
        tick();

        // Basic fill, then the same fill with the consumer stalled 5 cycles.
        do_fetch(32'h42, c_ord_42, c_line_a, 0);
        do_fetch(32'h42, c_ord_42, c_line_a, 5);

        // Simultaneous write-back and fill to 0x80: write-back goes first.
        i_wb_addr = 32'h80; i_wb_data = c_line_wb; i_wb_valid = 1'b1;
        i_fetch_addr = 32'h80; i_fetch_valid = 1'b1;
        @(negedge i_clk);
        check("wb_prio_ready", {o_wb_ready, o_fetch_ready}, 128'b10);
        tick();
        i_wb_valid = 1'b0; i_wb_data = '1; i_wb_addr = 32'h300;
        for (int k = 0; k < 4; k++) begin
            @(negedge i_clk);
            check("wr_en_we", {o_mem_en, o_mem_we, o_fetch_ready}, 128'b110);
            check("wr_addr", 128'(o_mem_addr), 128'(c_ord_80[k]));
            check("wr_data", 128'(o_mem_wdata), 128'(c_line_wb[k]));
            tick();
        end
        do_fetch(32'h80, c_ord_80, c_line_wb, 0);

        // Reset during READ at T+3: no response, RAM quiet from T+4.
        i_fetch_addr = 32'h42; i_fetch_valid = 1'b1;
        tick();
        i_fetch_valid = 1'b0;
        tick();
        tick();
        i_rst = 1'b1;
        @(negedge i_clk);
        check("rst_pre_en", 128'(o_mem_en), 128'd1);
        tick();
        i_rst = 1'b0;
        i_fetch_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge i_clk);
            check("rst_abort", {o_mem_en, o_fetch_valid}, 128'b00);
            tick();
        end
        i_fetch_ready = 1'b0;

        // Upper address bits beyond the RAM width are dropped.
        do_fetch(32'hFFFF_FC43, c_ord_43, c_line_a, 1);

        check("ram_wb_0", 128'(mem[10'h080]), 128'h11);
        check("ram_wb_3", 128'(mem[10'h083]), 128'h14);
        check("queue_drained", 128'(exp_q.size()), 128'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
